// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// hands fetched words to decode over valid/ready; taken branches redirect and flush.
//
// state | meaning
// ISSUE | drive imem_req for the current pc
// WAIT  | request outstanding, waiting for imem_valid
// HOLD  | word fetched while decode was stalled; parked in hold register
// DROP  | wrong-path response still in flight; swallow it
`timescale 1ns/1ps
module fetch_unit #(
  parameter int                PC_W     = 64,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  input  logic            br_taken,
  input  logic            uncond_br,
  input  logic [PC_W-1:0] br_pc,
  input  logic [31:0]     br_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_inc;
  logic            out_free;
  logic            unused_br_bits;

  // CB-format offset sits in [23:5], B-format in [25:0]; both are word offsets
  assign br_off = uncond_br ? {{(PC_W-28){br_instr[25]}}, br_instr[25:0], 2'b00}
                            : {{(PC_W-21){br_instr[23]}}, br_instr[23:5], 2'b00};
  assign br_target      = br_pc + br_off;
  assign pc_inc         = pc_q + PC_W'(4);
  assign out_free       = !id_valid_q || id_ready;
  assign unused_br_bits = ^{br_instr[31:26], br_instr[4:0]};

  assign imem_req  = rst && (state_q == S_ISSUE) && !br_taken;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (id_valid_q && id_ready) id_valid_d = 1'b0;

    if (br_taken) begin
      pc_d         = br_target;
      id_valid_d   = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      // a response landing with the redirect is simply discarded, no DROP needed
      if (state_q == S_WAIT && !imem_valid) state_d = S_DROP;
      else                                  state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            pc_d = pc_inc;
            if (out_free) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_data;
              id_pc_d    = pc_q;
              state_d    = S_ISSUE;
            end else begin
              hold_instr_d = imem_data;
              hold_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = hold_instr_q;
            id_pc_d    = hold_pc_q;
            state_d    = S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_valid) state_d = S_ISSUE;
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// program-order reference model and a latency-programmable memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic        br_taken = 1'b0;
  logic        uncond_br = 1'b0;
  logic [63:0] br_pc = '0;
  logic [31:0] br_instr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  int n_vec = 0;
  int n_err = 0;

  // memory model state
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [63:0] mem_addr = '0;
  logic        stale = 1'b0;

  // per-cycle samples taken just before the active edge
  logic        s_req, s_valid, s_rdy, s_br, s_overlap;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  fetch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .br_taken(br_taken), .uncond_br(uncond_br), .br_pc(br_pc), .br_instr(br_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h9100_0421;
    if (a == 64'h4) return 32'hAB02_03E3;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] ref_target(input logic unc, input logic [63:0] bpc,
                                             input logic [31:0] ins);
    logic signed [25:0] f26;
    logic signed [18:0] f19;
    longint off;
    f26 = ins[25:0];
    f19 = ins[23:5];
    off = unc ? longint'(f26) : longint'(f19);
    return bpc + 64'(off * 4);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    br_taken = 1'b0; uncond_br = 1'b0; br_pc = '0; br_instr = '0;
    imem_valid = 1'b0; imem_data = '0; id_ready = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; stale = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // one clock cycle: memory model responds, inputs applied, outputs sampled
  task automatic tick(input logic br, input logic unc, input logic [63:0] bpc,
                      input logic [31:0] binstr, input logic rdy);
    @(negedge clk);
    imem_valid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_data  = mem_word(mem_addr);
        mem_busy   = 1'b0;
        stale      = 1'b0;
      end
    end
    br_taken = br; uncond_br = unc; br_pc = bpc; br_instr = binstr; id_ready = rdy;
    if (br && mem_busy) stale = 1'b1;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    s_valid = id_valid; s_pc = id_pc; s_instr = id_instr;
    s_rdy = rdy; s_br = br;
    s_overlap = imem_req && mem_busy;
    if (imem_req) begin
      mem_busy = 1'b1; mem_cnt = mem_lat; mem_addr = imem_addr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (id_valid !== 1'b0 || id_pc !== 64'h0 || id_instr !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: valid=%b pc=%h instr=%h, want 0/0/0", id_valid, id_pc, id_instr);
    end
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL reset_req: req=%b addr=%h, want req=0 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h0) begin
      n_err++; $display("FAIL basic_req0: req=%b addr=%h, want 1/0", s_req, s_addr);
    end
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b0) begin
      n_err++; $display("FAIL basic_wait_noreq: req=%b, want 0", s_req);
    end
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h4 || s_valid !== 1'b1 || s_pc !== 64'h0 || s_instr !== 32'h9100_0421) begin
      n_err++; $display("FAIL basic_word0: req=%b addr=%h valid=%b pc=%h instr=%h, want 1/4/1/0/91000421",
                        s_req, s_addr, s_valid, s_pc, s_instr);
    end
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_gap: req=%b valid=%b, want 0/0", s_req, s_valid);
    end
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h8 || s_valid !== 1'b1 || s_pc !== 64'h4 || s_instr !== 32'hAB02_03E3) begin
      n_err++; $display("FAIL basic_word1: req=%b addr=%h valid=%b pc=%h instr=%h, want 1/8/1/4/ab0203e3",
                        s_req, s_addr, s_valid, s_pc, s_instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(0, 0, '0, '0, 1'b0);
    tick(0, 0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, '0, '0, 1'b0);
      n_vec++;
      if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_instr !== 32'h9100_0421) begin
        n_err++; $display("FAIL bp_stable[%0d]: valid=%b pc=%h instr=%h, want 1/0/91000421", i, s_valid, s_pc, s_instr);
      end
      n_vec++;
      if (s_req !== (i == 0) || (i == 0 && s_addr !== 64'h4)) begin
        n_err++; $display("FAIL bp_req[%0d]: req=%b addr=%h, want req=%0d", i, s_req, s_addr, (i == 0));
      end
    end
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 64'h4 || s_instr !== 32'hAB02_03E3 || s_req !== 1'b1 || s_addr !== 64'h8) begin
      n_err++; $display("FAIL bp_release: valid=%b pc=%h instr=%h req=%b addr=%h, want 1/4/ab0203e3/1/8",
                        s_valid, s_pc, s_instr, s_req, s_addr);
    end
  endtask

  task automatic test_uncond_branch();
    do_reset();
    tick(0, 0, '0, '0, 1'b0);
    tick(0, 0, '0, '0, 1'b0);
    tick(1, 1, 64'h10, 32'h03FF_FFFE, 1'b0);
    n_vec++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      n_err++; $display("FAIL ub_cycle: req=%b valid=%b, want 0/1", s_req, s_valid);
    end
    tick(0, 0, '0, '0, 1'b0);
    n_vec++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 64'h8) begin
      n_err++; $display("FAIL ub_target: valid=%b req=%b addr=%h, want 0/1/8", s_valid, s_req, s_addr);
    end
  endtask

  task automatic test_cond_branch_wait();
    do_reset();
    mem_lat = 3;
    tick(0, 0, '0, '0, 1'b1);
    tick(1, 0, 64'h20, 32'h0000_0060, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, '0, '0, 1'b1);
      n_vec++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        n_err++; $display("FAIL cb_drop[%0d]: req=%b valid=%b, want 0/0", i, s_req, s_valid);
      end
    end
    mem_lat = 1;
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h2C || s_valid !== 1'b0) begin
      n_err++; $display("FAIL cb_target: req=%b addr=%h valid=%b, want 1/2c/0", s_req, s_addr, s_valid);
    end
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 64'h2C || s_instr !== mem_word(64'h2C)) begin
      n_err++; $display("FAIL cb_word: valid=%b pc=%h instr=%h, want 1/2c/%h", s_valid, s_pc, s_instr, mem_word(64'h2C));
    end
  endtask

  task automatic test_branch_with_response();
    do_reset();
    tick(0, 0, '0, '0, 1'b1);
    tick(1, 1, 64'h100, 32'h0000_0005, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h114 || s_valid !== 1'b0) begin
      n_err++; $display("FAIL bwr_target: req=%b addr=%h valid=%b, want 1/114/0", s_req, s_addr, s_valid);
    end
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 64'h114 || s_instr !== mem_word(64'h114)) begin
      n_err++; $display("FAIL bwr_word: valid=%b pc=%h instr=%h, want 1/114/%h", s_valid, s_pc, s_instr, mem_word(64'h114));
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    tick(1, 1, 64'h0, 32'h03FF_FFFF, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++; $display("FAIL wrap_top: req=%b addr=%h, want 1/fffffffffffffffc", s_req, s_addr);
    end
    tick(0, 0, '0, '0, 1'b1);
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 64'hFFFF_FFFF_FFFF_FFFC || s_req !== 1'b1 || s_addr !== 64'h0) begin
      n_err++; $display("FAIL wrap_next: valid=%b pc=%h req=%b addr=%h, want 1/fffffffffffffffc/1/0",
                        s_valid, s_pc, s_req, s_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(0, 0, '0, '0, 1'b0);
    tick(0, 0, '0, '0, 1'b0);
    mem_lat = 3;
    tick(0, 0, '0, '0, 1'b0);
    tick(0, 0, '0, '0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL areset: valid=%b req=%b addr=%h, want 0/0/0", id_valid, imem_req, imem_addr);
    end
    do_reset();
    tick(0, 0, '0, '0, 1'b1);
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== 64'h0 || s_valid !== 1'b0) begin
      n_err++; $display("FAIL areset_restart: req=%b addr=%h valid=%b, want 1/0/0", s_req, s_addr, s_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, p_pc, bpc;
    logic [31:0] p_instr, binstr;
    logic        prev_hold, rdy, br, unc;
    int          n_xfer;
    do_reset();
    exp_pc = 64'h0; prev_hold = 1'b0; p_pc = '0; p_instr = '0; n_xfer = 0;
    for (int c = 0; c < 800; c++) begin
      mem_lat = $urandom_range(1, 4);
      rdy     = ($urandom_range(0, 3) != 0);
      br      = !stale && ($urandom_range(0, 11) == 0);
      unc     = 1'($urandom_range(0, 1));
      bpc     = {$urandom, $urandom} & ~64'h3;
      binstr  = $urandom;
      tick(br, unc, bpc, binstr, rdy);
      n_vec++;
      if (s_overlap) begin
        n_err++; $display("FAIL rnd_outstanding[%0d]: req=%b while busy, want single outstanding", c, s_req);
      end
      if (prev_hold) begin
        n_vec++;
        if (s_valid !== 1'b1 || s_pc !== p_pc || s_instr !== p_instr) begin
          n_err++; $display("FAIL rnd_stable[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", c, s_valid, s_pc, s_instr, p_pc, p_instr);
        end
      end
      if (s_valid && s_rdy) begin
        n_vec++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL rnd_xfer[%0d]: pc=%h instr=%h, want %h/%h", c, s_pc, s_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
        n_xfer++;
      end
      if (s_br) exp_pc = ref_target(unc, bpc, binstr);
      prev_hold = s_valid && !s_rdy && !s_br;
      p_pc = s_pc; p_instr = s_instr;
    end
    n_vec++;
    if (n_xfer < 40) begin
      n_err++; $display("FAIL rnd_throughput: transfers=%0d, want at least 40", n_xfer);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_uncond_branch();
    test_cond_branch_wait();
    test_branch_with_response();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
